// File: rtl/sig_frame_scheduler.sv
// Frame sequencer ahead of the hamming window: cuts the audio stream into
// 50%-overlapped frames, replaying the overlap half from a local buffer.
module sig_frame_scheduler #(
    parameter int FRAME_LEN = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] audio_out,
    input  logic        audio_valid,
    output logic        audio_rdy,
    output logic [15:0] win_audio_out,
    output logic        win_audio_valid,
    input  logic        win_audio_rdy,
    output logic        win_init,
    input  logic        win_retire,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_idx,
    output logic        busy
);

    localparam int HOP = FRAME_LEN / 2;
    localparam int AW  = $clog2(HOP);
    localparam int CW  = $clog2(FRAME_LEN) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
    localparam logic [CW-1:0] CNT_HOP  = CW'(HOP);
    localparam logic [AW-1:0] ADDR_END = '1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FILL,
        RD,
        RPL,
        NEW,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] s_cnt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] b_addr;
    logic          stop_req;

    logic [15:0]   mem [HOP];
    logic [15:0]   rd_data;
    logic          hs;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // Pass-through in FILL/NEW is purely combinational; replay shows RAM data.
    always_comb begin
        win_audio_out   = '0;
        win_audio_valid = 1'b0;
        audio_rdy       = 1'b0;
        unique case (state)
            FILL, NEW: begin
                win_audio_out   = audio_out;
                win_audio_valid = audio_valid;
                audio_rdy       = win_audio_rdy;
            end
            RPL: begin
                win_audio_out   = rd_data;
                win_audio_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign hs          = win_audio_valid && win_audio_rdy;
    assign frame_start = hs && (s_cnt == '0);
    assign frame_done  = (state == DRAIN) && (r_cnt == CNT_FULL);

    // Frame 0 stores its second half by sample position; later frames
    // overwrite the slot just replayed, so the buffer always holds the
    // newest HOP samples in arrival order starting at address 0.
    assign wr_en   = hs && (((state == FILL) && (s_cnt >= CNT_HOP))
                            || (state == NEW));
    assign wr_addr = (state == FILL) ? s_cnt[AW-1:0] : b_addr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= audio_out;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RD) begin
            rd_data <= mem[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s_cnt    <= '0;
            r_cnt    <= '0;
            b_addr   <= '0;
            stop_req <= 1'b0;
            win_init <= 1'b0;
            busy     <= 1'b0;
            frame_idx <= '0;
        end else begin
            if (state != IDLE && win_retire) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (state != IDLE && stop) begin
                stop_req <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        frame_idx <= '0;
                        s_cnt     <= '0;
                        r_cnt     <= '0;
                        b_addr    <= '0;
                        stop_req  <= 1'b0;
                        win_init  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    win_init <= 1'b0;
                    state    <= FILL;
                end
                FILL: begin
                    if (hs) begin
                        s_cnt <= s_cnt + 1'b1;
                        if (s_cnt == CNT_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                RD: begin
                    state <= RPL;
                end
                RPL: begin
                    if (hs) begin
                        s_cnt  <= s_cnt + 1'b1;
                        b_addr <= b_addr + 1'b1;
                        state  <= (b_addr == ADDR_END) ? NEW : RD;
                    end
                end
                NEW: begin
                    if (hs) begin
                        s_cnt  <= s_cnt + 1'b1;
                        b_addr <= b_addr + 1'b1;
                        if (s_cnt == CNT_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_cnt == CNT_FULL) begin
                        s_cnt <= '0;
                        r_cnt <= '0;
                        // A stop arriving on the final cycle still counts.
                        if (stop_req || stop) begin
                            stop_req <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            frame_idx <= frame_idx + 1'b1;
                            state     <= RD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_frame_scheduler.sv
// Randomized bench for sig_frame_scheduler: emulates the window block and
// checks every window sample against frame/hop arithmetic on the input stream.
module tb_sig_frame_scheduler;

    localparam int FL   = 512;
    localparam int HOP  = FL / 2;
    localparam int SLEN = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        audio_rdy;
    logic [15:0] win_audio_out;
    logic        win_audio_valid;
    logic        win_audio_rdy;
    logic        win_init;
    logic        win_retire;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_idx;
    logic        busy;

    always #5 clk = ~clk;

    sig_frame_scheduler #(.FRAME_LEN(FL)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .audio_out       (audio_out),
        .audio_valid     (audio_valid),
        .audio_rdy       (audio_rdy),
        .win_audio_out   (win_audio_out),
        .win_audio_valid (win_audio_valid),
        .win_audio_rdy   (win_audio_rdy),
        .win_init        (win_init),
        .win_retire      (win_retire),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .frame_idx       (frame_idx),
        .busy            (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] stream [SLEN];
    int next_in = 0;
    int base = 0;
    int got = 0;
    int ret = 0;
    int done_cnt = 0;
    int init_seen = 0;
    int dly = 0;
    bit done_due = 0;
    bit inflight = 0;
    bit hold = 0;
    bit hold_chk = 0;
    bit obs_valid = 0;
    bit obs_rdy = 0;
    bit obs_busy = 0;

    // Sample n of a session: frame n/FL starts HOP inputs after the last.
    function automatic logic [15:0] model(input int n);
        return stream[(base + (n / FL) * HOP + (n % FL)) % SLEN];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit hs;
        bit ihs;
        @(negedge clk);
        hs = win_audio_valid && win_audio_rdy;
        ihs = audio_valid && audio_rdy;
        obs_valid = win_audio_valid;
        obs_rdy = audio_rdy;
        obs_busy = busy;
        check("frame_done", 32'(frame_done), 32'(done_due));
        if (frame_done) done_cnt++;
        done_due = 0;
        if (win_init) init_seen++;
        check("frame_start", 32'(frame_start), 32'(hs && (got % FL == 0)));
        if (hold_chk) begin
            check("hold_valid", 32'(win_audio_valid), 32'(1));
            check("hold_data", 32'(win_audio_out), 32'(model(got)));
            check("hold_in_rdy", 32'(audio_rdy), 32'(0));
        end
        if (hs) begin
            check("win_data", 32'(win_audio_out), 32'(model(got)));
            if (got % FL == 0) begin
                check("frame_idx", 32'(frame_idx), 32'(got / FL));
            end
            got++;
            inflight = 1;
            dly = $urandom_range(1, 6);
        end
        if (win_retire) begin
            ret++;
            if (ret % FL == 0) done_due = 1;
        end
        if (ihs) next_in++;
        @(posedge clk);
        #1;
        win_retire = 0;
        if (inflight) begin
            dly--;
            if (dly == 0) begin
                win_retire = 1;
                inflight = 0;
            end
        end
        win_audio_rdy = !inflight && !win_retire && !hold
                        && ($urandom_range(0, 3) != 0);
        audio_valid = ($urandom_range(0, 4) != 0);
        audio_out = stream[next_in % SLEN];
    endtask

    task automatic wait_got(input int target, input string tag);
        int n = 0;
        while (got < target && n < 20000) begin
            step();
            n++;
        end
        check(tag, 32'(got), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (obs_busy && n < 20000);
        check(tag, 32'(obs_busy), 32'(0));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(win_audio_valid), 32'(0));
        check({tag, "_in_rdy"}, 32'(audio_rdy), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_init"}, 32'(win_init), 32'(0));
        check({tag, "_done"}, 32'(frame_done), 32'(0));
        check({tag, "_fstart"}, 32'(frame_start), 32'(0));
        check({tag, "_idx"}, 32'(frame_idx), 32'(0));
        check({tag, "_data"}, 32'(win_audio_out), 32'(0));
    endtask

    task automatic start_session(input bit with_stop);
        base = next_in;
        got = 0;
        ret = 0;
        done_cnt = 0;
        init_seen = 0;
        done_due = 0;
        start = 1;
        stop = with_stop;
        step();
        start = 0;
        stop = 0;
        check("init_pulse", 32'(win_init), 32'(1));
        check("busy_on", 32'(busy), 32'(1));
        check("init_no_valid", 32'(win_audio_valid), 32'(0));
        step();
        audio_valid = 1;
        #1;
        check("init_cleared", 32'(win_init), 32'(0));
        check("fill_valid", 32'(win_audio_valid), 32'(1));
        check("fill_data", 32'(win_audio_out), 32'(stream[next_in % SLEN]));
    endtask

    initial begin
        int n;
        for (int i = 0; i < SLEN; i++) stream[i] = 16'($urandom);
        rst = 1;
        start = 0;
        stop = 0;
        audio_valid = 1;
        audio_out = stream[0];
        win_audio_rdy = 1;
        win_retire = 0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 0;
        step();

        // Session 1: frames 0..2, start during DRAIN, backpressure, stop.
        start_session(0);
        wait_got(FL, "s1_f0_reach");
        start = 1;
        step();
        start = 0;
        check("drain_start_idx", 32'(frame_idx), 32'(0));
        check("drain_start_busy", 32'(busy), 32'(1));
        wait_got(FL + 50, "s1_replay_reach");
        hold = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_valid && n < 8);
        check("hold_reach", 32'(obs_valid), 32'(1));
        hold_chk = 1;
        repeat (10) step();
        hold_chk = 0;
        hold = 0;
        check("hold_no_adv", 32'(got), 32'(FL + 50));
        wait_got(2 * FL + 100, "s1_f2_reach");
        stop = 1;
        step();
        stop = 0;
        wait_idle("s1_idle");
        check("s1_total", 32'(got), 32'(3 * FL));
        check("s1_done_cnt", 32'(done_cnt), 32'(3));
        check("s1_idx", 32'(frame_idx), 32'(2));
        check("s1_init_cnt", 32'(init_seen), 32'(1));
        repeat (20) begin
            step();
            check("idle_in_rdy", 32'(obs_rdy), 32'(0));
            check("idle_valid", 32'(obs_valid), 32'(0));
        end

        // Session 2: reset in the middle of frame 0.
        start_session(0);
        wait_got(300, "s2_reach");
        rst = 1;
        step();
        rst = 0;
        inflight = 0;
        win_retire = 0;
        done_due = 0;
        audio_valid = 1;
        win_audio_rdy = 1;
        #1;
        check_quiet("midreset");
        step();

        // Session 3: start and stop together, stop dropped; stop in frame 1.
        start_session(1);
        wait_got(FL + 5, "s3_f1_reach");
        stop = 1;
        step();
        stop = 0;
        wait_idle("s3_idle");
        check("s3_total", 32'(got), 32'(2 * FL));
        check("s3_done_cnt", 32'(done_cnt), 32'(2));
        check("s3_idx", 32'(frame_idx), 32'(1));
        check("s3_init_cnt", 32'(init_seen), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sig_frame_scheduler.md
# sig_frame_scheduler

Frame sequencer that sits in front of `sig_hamming_window`. It cuts the incoming 16-bit audio stream into 50%-overlapped frames of `FRAME_LEN` samples, replays the overlap half from a local buffer, and feeds the window block one sample at a time. It also issues the window block's `init` at session start and tracks sample retirement on the window's zcr output to report frame boundaries to downstream feature logic.

## Interface
- `FRAME_LEN`, 512: samples per frame; power of two; must equal the hamming coefficient table length (512).
- `HOP` (localparam), `FRAME_LEN/2`: new samples per frame after frame 0; also the depth of the overlap buffer.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a session from IDLE.
- `stop` in 1: single-cycle pulse; requests a stop after the current frame.
- `audio_out` in 16: input sample, two's complement.
- `audio_valid` in 1: input sample valid.
- `audio_rdy` out 1: input sample accepted this cycle.
- `win_audio_out` out 16: sample to window block.
- `win_audio_valid` out 1: sample valid to window block.
- `win_audio_rdy` in 1: window block accepts (its `audio_rdy`).
- `win_init` out 1: init pulse to window block.
- `win_retire` in 1: high for one cycle when the window block completes a sample (`zcr_window_valid & zcr_window_rdy`, ANDed outside).
- `frame_start` out 1: pulse on the first sample of each frame accepted by the window.
- `frame_done` out 1: pulse when all `FRAME_LEN` samples of a frame have retired.
- `frame_idx` out 16: index of the current or most recent frame.
- `busy` out 1: high in every state except IDLE.

## Operation
- Overlap buffer: `HOP`x16 synchronous RAM, 1-cycle read latency, single port. Address counter `b_addr` is log2(`HOP`) bits.
- Counters:
  - `s_cnt`: samples accepted by the window in the current frame, 0..`FRAME_LEN`.
  - `r_cnt`: samples retired in the current frame, 0..`FRAME_LEN`.
- States:
  - IDLE: wait for `start`. On `start`, clear `frame_idx`, clear counters, go to INIT.
  - INIT: assert `win_init` for 1 cycle, go to FILL.
  - FILL (frame 0 only): pass through combinationally.
    - `win_audio_out=audio_out`, `win_audio_valid=audio_valid`, `audio_rdy=win_audio_rdy`.
    - Each handshake increments `s_cnt`.
    - Samples with `s_cnt >= HOP` are also written to buffer address `s_cnt-HOP`.
    - When `s_cnt` reaches `FRAME_LEN`, go to DRAIN.
  - RD: drive buffer address `b_addr`, go to RPL.
  - RPL: present the registered RAM data with `win_audio_valid=1`; `audio_rdy=0`.
    - On `win_audio_rdy`: increment `s_cnt` and `b_addr`.
    - Next state is NEW if `b_addr` was `HOP-1` (b_addr wraps to 0), else RD.
  - NEW: pass through as in FILL.
    - Each accepted sample is written to buffer address `b_addr`; `b_addr` increments.
    - After `HOP` samples (`s_cnt==FRAME_LEN`), go to DRAIN.
    - There is no read/write hazard: the replay of all `HOP` entries completes before the first write.
  - DRAIN: `win_audio_valid=0`, `audio_rdy=0`. When `r_cnt==FRAME_LEN`:
    - pulse `frame_done` and clear both counters;
    - if the stop latch is set, clear it and go to IDLE;
    - else increment `frame_idx` and go to RD.
- `r_cnt` increments on `win_retire` in every non-IDLE state. At most one sample is in flight inside the window block.
- `frame_start` is asserted in the cycle where the window handshake completes with `s_cnt==0`.
- The window coefficient address wraps naturally at `FRAME_LEN` = 512. `win_init` is issued only in INIT, never between frames.
- `stop`:
  - latched in any non-IDLE state;
  - ignored in IDLE.
- `start` outside IDLE is ignored.
- `frame_idx` wraps from 0xFFFF to 0.
- Simultaneous `start` and `stop` in IDLE: `start` wins and `stop` is dropped.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, stop latch 0. Buffer contents are not reset.
- Reset is honoured in any state, including mid-frame. The window block must be reset or re-initialised by the same `rst`.
- Pass-through in FILL/NEW has zero latency and no register; `audio_rdy` depends combinationally on `win_audio_rdy`.
- Replay issues at most one sample per 2 cycles (RD, RPL). `win_audio_out` is held stable while `win_audio_valid=1` and `win_audio_rdy=0`.
- `frame_done` is asserted 1 cycle after the cycle in which the `FRAME_LEN`-th `win_retire` is sampled.
- Cycles from `start` to the first `win_audio_valid`: 2 (INIT, then FILL). `win_audio_valid` in FILL also requires `audio_valid`.

## Test plan
- Frame 0: `start`, feed ramp 0..511 with the window always ready and retire 6 cycles after acceptance.
  - Required: `win_init` pulses once, `win_audio_out` = 0..511 in order, `frame_start` on sample 0, `frame_done` once, `frame_idx`=0.
- Overlap: continue the ramp 512..767.
  - Required: the frame 1 window sequence is 256..511 (replayed), then 512..767; `frame_idx`=1.
  - Frame 2 begins with 512..767.
- Backpressure: hold `win_audio_rdy` low 10 cycles mid-replay.
  - Required: `win_audio_out` stable, no `b_addr` advance, no sample dropped or duplicated.
- Stop: pulse `stop` at sample 100 of frame 1.
  - Required: frame 1 completes, `frame_done`, return to IDLE, `busy`=0, `audio_rdy` stays 0 after.
- Reset mid-frame: assert `rst` at sample 300 of frame 0.
  - Required: next cycle all outputs 0, IDLE.
  - A new `start` reproduces the frame-0 behaviour with a fresh `win_init`.
- `start` pulsed during DRAIN: ignored; `frame_idx` and state unchanged.
